reg_index_file: RTL and testbench
=================================

Name: reg_index_file

Overview:
- Parametrised successor of the 6502 X/Y index register: a clocked bank of NUM_REGS index registers (X=0, Y=1 by default).
- Adds a load path, INC/DEC (INX/INY/DEX/DEY) and register-to-register transfer.
- Provides a latched bus output and registered N/Z flag results for the status register.
- Sits between the internal data bus and the ALU/status logic of the CPU core.

Parameters:
- WIDTH, 8, data width of each register and of the bus.
- NUM_REGS, 2, number of index registers; must be >= 2.
- SELW, $clog2(NUM_REGS), width of the register-select fields (derived; not overridden).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous reset, active-high.
- SEL  input  SELW  target register for LOAD/INC/DEC; also the destination for XFER.
- SRC  input  SELW  source register for XFER.
- DATA  input  WIDTH  bus data for LOAD.
- LOAD  input  1  write DATA into reg[SEL].
- XFER  input  1  write reg[SRC] into reg[SEL].
- INC  input  1  reg[SEL] <= reg[SEL] + 1.
- DEC  input  1  reg[SEL] <= reg[SEL] - 1.
- BUS_ENABLE  input  1  capture reg[SEL] onto DATA_OUT.
- DATA_OUT  output  WIDTH  last captured register value; holds between captures.
- N_FLAG  output  1  MSB of the last written result.
- Z_FLAG  output  1  1 when the last written result was zero.
- FLAG_VALID  output  1  1-cycle pulse, the cycle after any register write.

Behaviour:
- Reset (asynchronous, RST=1) sets:
  - all registers to 0;
  - DATA_OUT to 0;
  - N_FLAG, Z_FLAG and FLAG_VALID to 0.
- RST dominates every other input, including a reset asserted mid-operation. Operations resume on the first rising edge after RST deasserts.
- One write operation per cycle. Priority is LOAD > XFER > INC > DEC.
- INC and DEC both high, with no LOAD or XFER: no write, no flag update, FLAG_VALID stays 0.
- Arithmetic is modulo 2^WIDTH:
  - INC on all-ones wraps to 0 (Z=1).
  - DEC on 0 wraps to all-ones (N=1).
- XFER with SRC==SEL rewrites the same value. It counts as a write: flags update and FLAG_VALID pulses.
- Write latency is 1 cycle: the new value is visible in the bank and to BUS_ENABLE from the next cycle.
- N_FLAG, Z_FLAG and FLAG_VALID are registered and valid in the cycle after the write. Flags hold their value when there is no write.
- BUS_ENABLE is independent of the write path and uses read-before-write. If BUS_ENABLE and a write to the same SEL occur in one cycle, DATA_OUT gets the old value.
- When BUS_ENABLE=0, DATA_OUT holds its value.
- SEL or SRC >= NUM_REGS (non-power-of-two configurations):
  - writes are ignored, with no flag update;
  - a BUS_ENABLE capture yields 0.
- No internal FSM beyond the register bank, the output latch and the flag/valid pipeline stage.

Optional Feature:
- Macro: REG_INDEX_WRAP_EN.
- With the macro defined: an extra output port WRAP (1 bit), registered.
  - Pulses 1 for one cycle, aligned with FLAG_VALID, when INC wraps all-ones->0 or DEC wraps 0->all-ones.
  - Resets to 0.
- Without the macro: the WRAP port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include (cpu_defs):
  - register index constants IDX_X=0 and IDX_Y=1;
  - default WIDTH=8.
- Sub-module reg_index_flags: combinational N/Z computation from the WIDTH-bit result, instantiated once. The top level registers its outputs.

Test Plan:
- Reset and capture: assert RST mid-run, release, then BUS_ENABLE with SEL=X -> DATA_OUT=00, N=0, Z=0, FLAG_VALID=0.
- Load and read-before-write:
  - LOAD X=AA -> next cycle FLAG_VALID=1, N=1, Z=0.
  - LOAD Y=FF and BUS_ENABLE SEL=Y in the same cycle -> DATA_OUT=00.
  - Next BUS_ENABLE on Y -> DATA_OUT=FF.
- Wrap arithmetic:
  - Y=FF, INC -> Y=00, Z=1, N=0 (WRAP=1 if REG_INDEX_WRAP_EN).
  - X=00, DEC -> X=FF, N=1.
- Priority:
  - LOAD+INC+DEC on X with DATA=05 -> X=05.
  - INC+DEC alone -> X unchanged, FLAG_VALID=0.
- Transfer: X=7F, XFER SRC=X SEL=Y -> Y=7F, N=0, Z=0; X unchanged.
- Parameter sweep: WIDTH=16, NUM_REGS=3:
  - INC at FFFF -> 0000, Z=1.
  - SEL=3 writes ignored; BUS_ENABLE at SEL=3 -> 0000.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU core definitions: index register numbering and default data width.
package cpu_defs;

    localparam int DEF_WIDTH = 8;
    localparam int IDX_X     = 0;
    localparam int IDX_Y     = 1;

endpackage

// File: rtl/reg_index_flags.sv
// Combinational N/Z status computation for a WIDTH-bit register result.
module reg_index_flags
    import cpu_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_result,
    output logic             o_n,
    output logic             o_z
);

    // Negative is the sign bit, zero is a full-width compare.
    always_comb begin
        o_n = i_result[WIDTH-1];
        o_z = (i_result == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/reg_index_file.sv
// Index register bank (6502 X/Y successor) with load, INC/DEC, transfer, bus latch and N/Z flags.
// Optional feature: define REG_INDEX_WRAP_EN to add the registered WRAP output.
module reg_index_file
    import cpu_defs::*;
#(
    parameter int  WIDTH    = DEF_WIDTH,
    parameter int  NUM_REGS = 2,
    localparam int SELW     = $clog2(NUM_REGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SELW-1:0]  SEL,
    input  logic [SELW-1:0]  SRC,
    input  logic [WIDTH-1:0] DATA,
    input  logic             LOAD,
    input  logic             XFER,
    input  logic             INC,
    input  logic             DEC,
    input  logic             BUS_ENABLE,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             N_FLAG,
    output logic             Z_FLAG,
`ifdef REG_INDEX_WRAP_EN
    output logic             WRAP,
`endif
    output logic             FLAG_VALID
);

    localparam logic [SELW:0]    NUM_REGS_W = (SELW+1)'(NUM_REGS);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_regs [NUM_REGS];
    logic [WIDTH-1:0] r_data_out;
    logic             r_n_flag;
    logic             r_z_flag;
    logic             r_flag_valid;

    logic             w_sel_ok;
    logic             w_src_ok;
    logic [WIDTH-1:0] w_sel_val;
    logic [WIDTH-1:0] w_src_val;
    logic             w_we;
    logic [WIDTH-1:0] w_wdata;
    logic             w_n;
    logic             w_z;

    // Out-of-range selects (non-power-of-two banks) read as zero and block writes.
    always_comb begin
        w_sel_ok  = ({1'b0, SEL} < NUM_REGS_W);
        w_src_ok  = ({1'b0, SRC} < NUM_REGS_W);
        if (w_sel_ok) begin
            w_sel_val = r_regs[SEL];
        end else begin
            w_sel_val = ZERO;
        end
        if (w_src_ok) begin
            w_src_val = r_regs[SRC];
        end else begin
            w_src_val = ZERO;
        end
    end

    // Write decode: LOAD > XFER > INC > DEC; INC and DEC together cancel out.
    always_comb begin
        w_we    = 1'b0;
        w_wdata = ZERO;
        if (LOAD) begin
            w_we    = w_sel_ok;
            w_wdata = DATA;
        end else if (XFER) begin
            w_we    = w_sel_ok & w_src_ok;
            w_wdata = w_src_val;
        end else if (INC && !DEC) begin
            w_we    = w_sel_ok;
            w_wdata = w_sel_val + ONE;
        end else if (DEC && !INC) begin
            w_we    = w_sel_ok;
            w_wdata = w_sel_val - ONE;
        end else begin
            w_we    = 1'b0;
            w_wdata = ZERO;
        end
    end

    reg_index_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .i_result (w_wdata),
        .o_n      (w_n),
        .o_z      (w_z)
    );

    // Register bank update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= ZERO;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_we && (SEL == SELW'(i))) begin
                    r_regs[i] <= w_wdata;
                end
            end
        end
    end

    // Bus latch samples the pre-write value, so a same-cycle write is not visible.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data_out <= ZERO;
        end else if (BUS_ENABLE) begin
            r_data_out <= w_sel_val;
        end
    end

    // Flags hold between writes; valid pulses for exactly the cycle after a write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_n_flag     <= 1'b0;
            r_z_flag     <= 1'b0;
            r_flag_valid <= 1'b0;
        end else begin
            r_flag_valid <= w_we;
            if (w_we) begin
                r_n_flag <= w_n;
                r_z_flag <= w_z;
            end
        end
    end

`ifdef REG_INDEX_WRAP_EN
    logic w_wrap;
    logic r_wrap;

    // Only a real INC/DEC write can wrap; LOAD/XFER take priority and never flag.
    always_comb begin
        w_wrap = w_sel_ok & ~LOAD & ~XFER &
                 ((INC & ~DEC & (w_sel_val == ALL_ONES)) |
                  (DEC & ~INC & (w_sel_val == ZERO)));
    end

    // Wrap pulse, aligned with the flag-valid stage.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap;
        end
    end

    assign WRAP = r_wrap;
`endif

    assign DATA_OUT   = r_data_out;
    assign N_FLAG     = r_n_flag;
    assign Z_FLAG     = r_z_flag;
    assign FLAG_VALID = r_flag_valid;

endmodule

// File: tb/tb_reg_index_file.sv
// Directed table-driven bench for reg_index_file: default 8-bit/2-reg build and a 16-bit/3-reg build.
module tb_reg_index_file;
    import cpu_defs::*;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  src;
        logic [15:0] data;
        logic        load;
        logic        xfer;
        logic        inc;
        logic        dec;
        logic        be;
        logic [15:0] exp_out;
        logic        exp_n;
        logic        exp_z;
        logic        exp_v;
        logic        exp_w;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        sel8, src8;
    logic [7:0]  data8, dout8;
    logic        load8, xfer8, inc8, dec8, be8, n8, z8, v8;
    logic [1:0]  sel16, src16;
    logic [15:0] data16, dout16;
    logic        load16, xfer16, inc16, dec16, be16, n16, z16, v16;
`ifdef REG_INDEX_WRAP_EN
    logic        wrap8, wrap16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vec_t tab8  [21];
    vec_t tab16 [16];

    always #5 clk = ~clk;

    reg_index_file u_dut8 (
        .CLK        (clk),
        .RST        (rst),
        .SEL        (sel8),
        .SRC        (src8),
        .DATA       (data8),
        .LOAD       (load8),
        .XFER       (xfer8),
        .INC        (inc8),
        .DEC        (dec8),
        .BUS_ENABLE (be8),
        .DATA_OUT   (dout8),
        .N_FLAG     (n8),
        .Z_FLAG     (z8),
`ifdef REG_INDEX_WRAP_EN
        .WRAP       (wrap8),
`endif
        .FLAG_VALID (v8)
    );

    reg_index_file #(
        .WIDTH    (16),
        .NUM_REGS (3)
    ) u_dut16 (
        .CLK        (clk),
        .RST        (rst),
        .SEL        (sel16),
        .SRC        (src16),
        .DATA       (data16),
        .LOAD       (load16),
        .XFER       (xfer16),
        .INC        (inc16),
        .DEC        (dec16),
        .BUS_ENABLE (be16),
        .DATA_OUT   (dout16),
        .N_FLAG     (n16),
        .Z_FLAG     (z16),
`ifdef REG_INDEX_WRAP_EN
        .WRAP       (wrap16),
`endif
        .FLAG_VALID (v16)
    );

    function automatic vec_t mk(input logic [1:0] sel, input logic [1:0] src, input logic [15:0] data,
                                input logic l, input logic x, input logic i, input logic d, input logic be,
                                input logic [15:0] eo, input logic en, input logic ez, input logic ev,
                                input logic ew);
        vec_t v;
        v.sel = sel; v.src = src; v.data = data;
        v.load = l; v.xfer = x; v.inc = i; v.dec = d; v.be = be;
        v.exp_out = eo; v.exp_n = en; v.exp_z = ez; v.exp_v = ev; v.exp_w = ew;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        sel8 = 1'b0; src8 = 1'b0; data8 = 8'h00;
        load8 = 1'b0; xfer8 = 1'b0; inc8 = 1'b0; dec8 = 1'b0; be8 = 1'b0;
        sel16 = 2'd0; src16 = 2'd0; data16 = 16'h0000;
        load16 = 1'b0; xfer16 = 1'b0; inc16 = 1'b0; dec16 = 1'b0; be16 = 1'b0;
    endtask

    task automatic check8(input string tag, input logic [15:0] eo, input logic en, input logic ez,
                          input logic ev);
        chk({tag, ".dout8"}, {8'h00, dout8}, eo);
        chk({tag, ".n8"}, {15'd0, n8}, {15'd0, en});
        chk({tag, ".z8"}, {15'd0, z8}, {15'd0, ez});
        chk({tag, ".v8"}, {15'd0, v8}, {15'd0, ev});
    endtask

    task automatic apply(input vec_t v, input bit big, input string tag);
        @(negedge clk);
        idle();
        if (big) begin
            sel16 = v.sel; src16 = v.src; data16 = v.data;
            load16 = v.load; xfer16 = v.xfer; inc16 = v.inc; dec16 = v.dec; be16 = v.be;
        end else begin
            sel8 = v.sel[0]; src8 = v.src[0]; data8 = v.data[7:0];
            load8 = v.load; xfer8 = v.xfer; inc8 = v.inc; dec8 = v.dec; be8 = v.be;
        end
        @(posedge clk);
        #1;
        if (big) begin
            chk({tag, ".dout16"}, dout16, v.exp_out);
            chk({tag, ".n16"}, {15'd0, n16}, {15'd0, v.exp_n});
            chk({tag, ".z16"}, {15'd0, z16}, {15'd0, v.exp_z});
            chk({tag, ".v16"}, {15'd0, v16}, {15'd0, v.exp_v});
`ifdef REG_INDEX_WRAP_EN
            chk({tag, ".wrap16"}, {15'd0, wrap16}, {15'd0, v.exp_w});
`endif
        end else begin
            check8(tag, v.exp_out, v.exp_n, v.exp_z, v.exp_v);
`ifdef REG_INDEX_WRAP_EN
            chk({tag, ".wrap8"}, {15'd0, wrap8}, {15'd0, v.exp_w});
`endif
        end
    endtask

    initial begin
        //                sel   src   data     L     X     I     D     BE    out       N     Z     V     W
        tab8[0]  = mk(2'd0, 2'd0, 16'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        tab8[1]  = mk(2'd1, 2'd0, 16'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        tab8[2]  = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tab8[3]  = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
        tab8[4]  = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tab8[5]  = mk(2'd0, 2'd0, 16'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        tab8[6]  = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        tab8[7]  = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        tab8[8]  = mk(2'd0, 2'd0, 16'h05, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
        tab8[9]  = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        tab8[10] = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        tab8[11] = mk(2'd0, 2'd0, 16'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h05, 1'b0, 1'b0, 1'b1, 1'b0);
        tab8[12] = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h05, 1'b0, 1'b0, 1'b1, 1'b0);
        tab8[13] = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        tab8[14] = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
        tab8[15] = mk(2'd1, 2'd1, 16'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
        tab8[16] = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7F, 1'b1, 1'b0, 1'b1, 1'b0);
        tab8[17] = mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h80, 1'b1, 1'b0, 1'b0, 1'b0);
        tab8[18] = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        tab8[19] = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h80, 1'b1, 1'b0, 1'b1, 1'b0);
        tab8[20] = mk(2'd1, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h80, 1'b1, 1'b0, 1'b0, 1'b0);

        tab16[0]  = mk(2'd0, 2'd0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        tab16[1]  = mk(2'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);
        tab16[2]  = mk(2'd2, 2'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tab16[3]  = mk(2'd2, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[4]  = mk(2'd3, 2'd0, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[5]  = mk(2'd3, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[6]  = mk(2'd0, 2'd0, 16'h00AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tab16[7]  = mk(2'd1, 2'd0, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        tab16[8]  = mk(2'd1, 2'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[9]  = mk(2'd3, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[10] = mk(2'd3, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[11] = mk(2'd1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[12] = mk(2'd3, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[13] = mk(2'd1, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        tab16[14] = mk(2'd1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        tab16[15] = mk(2'd0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1, 1'b0);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check8("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Mid-run reset: load and capture a value, then reset with a write pending.
        apply(mk(2'd0, 2'd0, 16'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0, "pre_load");
        apply(mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0, "pre_cap");
        @(negedge clk);
        idle();
        load8 = 1'b1; data8 = 8'h3C; be8 = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check8("async_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check8("rst_dominates", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        apply(mk(2'd0, 2'd0, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, "post_rst_cap");

        for (int i = 0; i < 21; i++) begin
            apply(tab8[i], 1'b0, $sformatf("w8_row%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            apply(tab16[i], 1'b1, $sformatf("w16_row%0d", i));
        end

        @(negedge clk);
        idle();
        @(posedge clk);
        #1;
        chk("idle_valid8", {15'd0, v8}, 16'h0000);
        chk("idle_dout16", dout16, 16'h00AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
